// File: rtl/link_seq_pkg.sv
// Shared definitions for the link sequencer slice.
// Contents:
//   - FSM state encodings and the state_e enum built from them
//   - ACT_NOP action code and the 2-bit completion status codes
//   - cmd_t, the packed host command as it is stored in the FIFO
//   - is_nop(), which classifies a command
package link_seq_pkg;

    localparam logic [1:0] IDLE_ENC       = 2'd0;
    localparam logic [1:0] WAIT_START_ENC = 2'd1;
    localparam logic [1:0] WAIT_DONE_ENC  = 2'd2;
    localparam logic [1:0] RESP_ENC       = 2'd3;

    typedef enum logic [1:0] {
        IDLE       = IDLE_ENC,
        WAIT_START = WAIT_START_ENC,
        WAIT_DONE  = WAIT_DONE_ENC,
        RESP       = RESP_ENC
    } state_e;

    localparam logic [2:0] ACT_NOP = 3'd0;

    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_START_TO = 2'b01;
    localparam logic [1:0] ST_DONE_TO  = 2'b10;
    localparam logic [1:0] ST_NOP      = 2'b11;

    // Field order sets the FIFO word layout: data in the MSBs, action in the LSBs.
    typedef struct packed {
        logic [7:0] data;
        logic       row;
        logic [1:0] col;
        logic [2:0] action;
    } cmd_t;

    localparam int CMD_W = 14;

    function automatic logic is_nop(input cmd_t c);
        return (c.action == ACT_NOP);
    endfunction

endpackage

// File: rtl/link_sequencer_cmd_fifo.sv
// cmd_fifo: synchronous FIFO that holds pending host commands.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i_wr_en, i_wr_data  write request and data; ignored while full
//   i_rd_en             pop the head entry; ignored while empty
//   o_rd_data           head entry (valid while not empty)
//   o_full, o_empty     registered status flags
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    // The extra MSB on each pointer tells a full FIFO apart from an empty one.
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic             r_full;
    logic             r_empty;

    logic             w_wr;
    logic             w_rd;
    logic [PW-1:0]    w_wr_ptr_nxt;
    logic [PW-1:0]    w_rd_ptr_nxt;

    assign w_wr         = i_wr_en && !r_full;
    assign w_rd         = i_rd_en && !r_empty;
    assign w_wr_ptr_nxt = w_wr ? (r_wr_ptr + PW'(1)) : r_wr_ptr;
    assign w_rd_ptr_nxt = w_rd ? (r_rd_ptr + PW'(1)) : r_rd_ptr;

    // Pointers and flags; the flags are computed from the next pointers, so they are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_empty  <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
            r_full   <= (w_wr_ptr_nxt[PW-1] != w_rd_ptr_nxt[PW-1]) &&
                        (w_wr_ptr_nxt[AW-1:0] == w_rd_ptr_nxt[AW-1:0]);
        end
    end

    // Storage array. It needs no reset: the pointer reset discards the contents.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];
    assign o_full    = r_full;
    assign o_empty   = r_empty;

endmodule

// File: rtl/link_sequencer.sv
// link_sequencer: queues host cell commands and drives them one at a time onto
// the shared transmitter/receiver bus. For each command it waits for the busy
// flags to rise and then fall, and it returns one status pulse per command.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cmd_valid/cmd_ready       host handshake; cmd_data/row/col/action form the payload
//   d, row, col, action       registered bus toward the transmitter and receiver
//   t_busy, r_busy            busy flags from the transmitter and receiver
//   resp_valid, resp_status   one-cycle completion pulse and its status code
//   idle                      FSM idle and no commands queued
module link_sequencer
    import link_seq_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int START_TO = 16,
    parameter int DONE_TO  = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_data,
    input  logic       cmd_row,
    input  logic [1:0] cmd_col,
    input  logic [2:0] cmd_action,
    output logic [7:0] d,
    output logic       row,
    output logic [1:0] col,
    output logic [2:0] action,
    input  logic       t_busy,
    input  logic       r_busy,
    output logic       resp_valid,
    output logic [1:0] resp_status,
    output logic       idle
);

    localparam int TMAX = (START_TO > DONE_TO) ? START_TO : DONE_TO;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] START_LAST = TW'(START_TO - 1);
    localparam logic [TW-1:0] DONE_LAST  = TW'(DONE_TO - 1);

    state_e          r_state;
    logic [TW-1:0]   r_timer;
    logic [7:0]      r_d;
    logic            r_row;
    logic [1:0]      r_col;
    logic [2:0]      r_action;
    logic            r_resp_valid;
    logic [1:0]      r_resp_status;

    cmd_t            w_in_cmd;
    cmd_t            w_head;
    logic [CMD_W-1:0] w_head_bits;
    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic            w_busy;

    assign w_in_cmd = {cmd_data, cmd_row, cmd_col, cmd_action};
    assign w_head   = cmd_t'(w_head_bits);
    assign w_pop    = (r_state == IDLE) && !w_empty;
    assign w_busy   = t_busy || r_busy;

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (cmd_valid),
        .i_wr_data (w_in_cmd),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head_bits),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    // Command FSM. The bus and response outputs are registered and updated on the
    // transitions, so RESP shows action = NOP together with the resp_valid pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_timer       <= '0;
            r_d           <= 8'd0;
            r_row         <= 1'b0;
            r_col         <= 2'd0;
            r_action      <= ACT_NOP;
            r_resp_valid  <= 1'b0;
            r_resp_status <= ST_OK;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        if (is_nop(w_head)) begin
                            // A NOP never reaches the bus; it is only acknowledged.
                            r_resp_valid  <= 1'b1;
                            r_resp_status <= ST_NOP;
                        end else begin
                            r_d      <= w_head.data;
                            r_row    <= w_head.row;
                            r_col    <= w_head.col;
                            r_action <= w_head.action;
                            r_timer  <= '0;
                            r_state  <= WAIT_START;
                        end
                    end
                end
                WAIT_START: begin
                    // On the last cycle, busy detection beats the timeout.
                    if (w_busy) begin
                        r_timer <= '0;
                        r_state <= WAIT_DONE;
                    end else if (r_timer == START_LAST) begin
                        r_action      <= ACT_NOP;
                        r_resp_valid  <= 1'b1;
                        r_resp_status <= ST_START_TO;
                        r_state       <= RESP;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!w_busy) begin
                        r_action      <= ACT_NOP;
                        r_resp_valid  <= 1'b1;
                        r_resp_status <= ST_OK;
                        r_state       <= RESP;
                    end else if (r_timer == DONE_LAST) begin
                        r_action      <= ACT_NOP;
                        r_resp_valid  <= 1'b1;
                        r_resp_status <= ST_DONE_TO;
                        r_state       <= RESP;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_action <= ACT_NOP;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = !w_full;
    assign d           = r_d;
    assign row         = r_row;
    assign col         = r_col;
    assign action      = r_action;
    assign resp_valid  = r_resp_valid;
    assign resp_status = r_resp_status;
    assign idle        = (r_state == IDLE) && w_empty;

endmodule
